// File: rtl/reduce_accum_unit.sv
// Streaming reduction unit: folds NUM_CONTRIB same-op/same-ID packets (sum, signed max/min)
// into one result packet; pass ops go straight through with one cycle of latency.
module reduce_accum_unit #(
    parameter int PKT_W       = 82,
    parameter int DATA_W      = 32,
    parameter int ID_W        = 8,
    parameter int NUM_CONTRIB = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W+2:0] in_packet,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PKT_W-1:0] out_packet,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             drop_pulse
);
    localparam int HDR_W = PKT_W - DATA_W;
    localparam int CNT_W = $clog2(NUM_CONTRIB + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CONTRIB);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PKT_W-1:0]   out_pkt_q, out_pkt_d;
    logic               out_valid_q, out_valid_d;
    logic               drop_q, drop_d;

    logic [2:0]         in_op;
    logic [PKT_W-1:0]   in_body;
    logic [DATA_W-1:0]  in_data;
    logic [HDR_W-1:0]   in_hdr;
    logic [ID_W-1:0]    in_id;
    logic [ID_W-1:0]    hdr_id;
    logic               accept;
    logic               in_is_reduce;
    logic [DATA_W-1:0]  acc_next;

    assign in_op        = in_packet[PKT_W+2:PKT_W];
    assign in_body      = in_packet[PKT_W-1:0];
    assign in_data      = in_body[DATA_W-1:0];
    assign in_hdr       = in_body[PKT_W-1:DATA_W];
    assign in_id        = in_body[PKT_W-1 -: ID_W];
    assign hdr_id       = hdr_q[HDR_W-1 -: ID_W];
    assign accept       = in_valid && in_ready;
    assign in_is_reduce = (in_op == 3'b001) || (in_op == 3'b010) || (in_op == 3'b011);

    function automatic logic [DATA_W-1:0] combine(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        case (op)
            3'b010:  combine = ($signed(b) > $signed(a)) ? b : a;
            3'b011:  combine = ($signed(b) < $signed(a)) ? b : a;
            default: combine = a + b;
        endcase
    endfunction

    assign acc_next = combine(op_q, acc_q, in_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            hdr_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_pkt_q   <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            hdr_q       <= hdr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_pkt_q   <= out_pkt_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
        end
    end

    // The result packet is assembled at the accepting edge so out_packet is a plain register.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        hdr_d       = hdr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_pkt_d   = out_pkt_q;
        out_valid_d = out_valid_q;
        drop_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_is_reduce) begin
                        op_d  = in_op;
                        hdr_d = in_hdr;
                        acc_d = in_data;
                        cnt_d = CNT_W'(1);
                        if (NUM_CONTRIB == 1) begin
                            out_pkt_d   = {in_hdr, in_data};
                            out_valid_d = 1'b1;
                            state_d     = EMIT;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        out_pkt_d   = in_body;
                        out_valid_d = 1'b1;
                        state_d     = EMIT;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (in_op == op_q && in_id == hdr_id) begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == CNT_LAST) begin
                            out_pkt_d   = {hdr_q, acc_next};
                            out_valid_d = 1'b1;
                            state_d     = EMIT;
                        end
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = !rst && (state_q != EMIT);
        out_packet = out_pkt_q;
        out_valid  = out_valid_q;
        drop_pulse = drop_q;
    end
endmodule

// File: tb/tb_reduce_accum_unit.sv
// Self-checking bench for reduce_accum_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reduction model.
module tb_reduce_accum_unit;
    localparam int PKT_W  = 82;
    localparam int DATA_W = 32;
    localparam int ID_W   = 8;
    localparam int N      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [PKT_W+2:0] in_packet;
    logic             in_valid;
    logic             in_ready;
    logic [PKT_W-1:0] out_packet;
    logic             out_valid;
    logic             out_ready;
    logic             drop_pulse;

    always #5 clk = ~clk;

    reduce_accum_unit #(
        .PKT_W(PKT_W), .DATA_W(DATA_W), .ID_W(ID_W), .NUM_CONTRIB(N)
    ) dut (
        .clk(clk), .rst(rst), .in_packet(in_packet), .in_valid(in_valid),
        .in_ready(in_ready), .out_packet(out_packet), .out_valid(out_valid),
        .out_ready(out_ready), .drop_pulse(drop_pulse)
    );

    int errors = 0;
    int checks = 0;
    int emits  = 0;
    int drops  = 0;
    logic [PKT_W-1:0] last_out = '0;
    bit started    = 1'b0;
    bit rand_ready = 1'b0;

    // Reference model: pending contributions kept as a list and folded when complete.
    bit               m_emit = 1'b0;
    bit               m_active = 1'b0;
    bit               m_drop = 1'b0;
    bit               m_rst_last = 1'b0;
    logic [2:0]       m_op = '0;
    logic [49:0]      m_hdr = '0;
    logic [31:0]      m_ops[$];
    logic [PKT_W-1:0] m_out = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fold(input logic [2:0] op);
        longint     s = 0;
        logic [31:0] r;
        r = m_ops[0];
        for (int i = 0; i < m_ops.size(); i++) begin
            s += longint'(m_ops[i]);
            if (op == 3'b010 && $signed(m_ops[i]) > $signed(r)) r = m_ops[i];
            if (op == 3'b011 && $signed(m_ops[i]) < $signed(r)) r = m_ops[i];
        end
        return (op == 3'b001) ? s[31:0] : r;
    endfunction

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("in_ready", in_ready, !rst && !m_emit);
            check("out_valid", out_valid, m_emit);
            check("drop_pulse", drop_pulse, m_drop);
            if (m_emit || m_rst_last) check("out_packet", out_packet, m_out);
            if (out_valid && out_ready) begin
                emits++;
                last_out = out_packet;
            end
            if (drop_pulse) drops++;
        end
        // advance model to the state after the coming rising edge
        m_rst_last = rst;
        m_drop = 1'b0;
        if (rst) begin
            m_emit = 1'b0;
            m_active = 1'b0;
            m_ops.delete();
            m_out = '0;
        end else if (m_emit) begin
            if (out_ready) m_emit = 1'b0;
        end else if (in_valid) begin
            logic [2:0]       op;
            logic [PKT_W-1:0] body;
            op   = in_packet[PKT_W+2:PKT_W];
            body = in_packet[PKT_W-1:0];
            if (!m_active) begin
                if (op >= 3'd1 && op <= 3'd3) begin
                    m_op  = op;
                    m_hdr = body[81:32];
                    m_ops.delete();
                    m_ops.push_back(body[31:0]);
                    m_active = 1'b1;
                end else begin
                    m_out  = body;
                    m_emit = 1'b1;
                end
            end else if (op == m_op && body[81:74] == m_hdr[49:42]) begin
                m_ops.push_back(body[31:0]);
            end else begin
                m_drop = 1'b1;
            end
            if (m_active && m_ops.size() == N) begin
                m_out    = {m_hdr, fold(m_op)};
                m_emit   = 1'b1;
                m_active = 1'b0;
            end
        end
    end

    task automatic tick();
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_raw(input logic [2:0] op, input logic [PKT_W-1:0] body);
        bit done = 1'b0;
        int budget = 60;
        in_packet = {op, body};
        in_valid  = 1'b1;
        while (!done && budget > 0) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #2;
            budget--;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] id, input logic [31:0] data);
        logic [41:0] mid;
        mid = 42'({$urandom(), $urandom()});
        send_raw(op, {id, mid, data});
    endtask

    task automatic wait_emit();
        bit done = 1'b0;
        int budget = 60;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!done && budget > 0) begin
            @(negedge clk);
            done = out_valid && out_ready;
            @(posedge clk);
            #2;
            budget--;
        end
        if (!done) check("emit_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0]      mm[4];
        logic [PKT_W-1:0] pat;
        int e0, d0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_packet = '0;
        @(posedge clk);
        started = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        idle(1);

        for (int i = 1; i <= 4; i++) send(3'b001, 8'h05, 32'(i));
        wait_emit();
        check("sum_id", last_out[81:74], 8'h05);
        check("sum_data", last_out[31:0], 32'd10);

        mm = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd3};
        for (int i = 0; i < 4; i++) send(3'b010, 8'h11, mm[i]);
        wait_emit();
        check("max_data", last_out[31:0], 32'd7);
        for (int i = 0; i < 4; i++) send(3'b011, 8'h12, mm[i]);
        wait_emit();
        check("min_data", last_out[31:0], 32'h8000_0000);

        mm = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0};
        for (int i = 0; i < 4; i++) send(3'b001, 8'h13, mm[i]);
        wait_emit();
        check("sum_wrap", last_out[31:0], 32'h0000_0001);

        pat = 82'h2AAAA_AAAAA_AAAAA_AAAAA_A;
        out_ready = 1'b0;
        send_raw(3'b000, pat);
        idle(5);
        wait_emit();
        check("pass000", last_out, pat);
        out_ready = 1'b0;
        send_raw(3'b101, pat);
        idle(5);
        wait_emit();
        check("pass101", last_out, pat);

        d0 = drops;
        send(3'b001, 8'h05, 32'd10);
        send(3'b001, 8'h05, 32'd20);
        send(3'b001, 8'h06, 32'd99);
        send(3'b001, 8'h05, 32'd30);
        send(3'b001, 8'h05, 32'd40);
        wait_emit();
        check("drop_count", 32'(drops - d0), 32'd1);
        check("drop_sum", last_out[31:0], 32'd100);

        e0 = emits;
        for (int i = 0; i < 3; i++) send(3'b001, 8'h05, 32'd100);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(3);
        check("rst_no_out", 32'(emits - e0), 32'd0);
        for (int i = 5; i <= 8; i++) send(3'b001, 8'h05, 32'(i));
        wait_emit();
        check("rst_fresh_cnt", 32'(emits - e0), 32'd1);
        check("rst_fresh_sum", last_out[31:0], 32'd26);

        rand_ready = 1'b1;
        for (int t = 0; t < 400; t++) begin
            logic [2:0]  op;
            logic [7:0]  id;
            logic [31:0] d;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 3));
                id = ($urandom_range(0, 7) == 0) ? 8'h06 : 8'h05;
                case ($urandom_range(0, 4))
                    0: d = 32'h8000_0000;
                    1: d = 32'h7FFF_FFFF;
                    2: d = 32'hFFFF_FFFF;
                    default: d = $urandom();
                endcase
                send(op, id, d);
            end
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
